// File: rtl/sd_otf_converter_if.sv
// Digit-stream and result bundle for the on-line to conventional converter.
// result_m exists only when SD_OTF_QM_OUT_EN is defined.
interface sd_otf_converter_if #(
    parameter int N = 16
) ();
    logic         enable;
    logic         start;
    logic [1:0]   digit;
    logic [N:0]   result;
    logic         busy;
    logic         done;
`ifdef SD_OTF_QM_OUT_EN
    logic [N:0]   result_m;
`endif

    modport master (
        output enable, start, digit,
`ifdef SD_OTF_QM_OUT_EN
        input  result_m,
`endif
        input  result, busy, done
    );

    modport slave (
        input  enable, start, digit,
`ifdef SD_OTF_QM_OUT_EN
        output result_m,
`endif
        output result, busy, done
    );
endinterface

// File: rtl/sd_otf_converter.sv
// Radix-2 MSD-first signed-digit stream to two's-complement converter (on-the-fly, no CPA).
// Optional feature macro SD_OTF_QM_OUT_EN exposes the Q-1 register as result_m.
module sd_otf_converter #(
    parameter int N = 16
) (
    input  logic              clk,
    input  logic              reset,
    sd_otf_converter_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N:0]      q_q, q_d;
    logic [N:0]      qm_q, qm_d;
    logic            busy_q, done_q;
    logic            accept_first, accept_next, accept;
    logic [N:0]      base_q, base_qm;

    function automatic logic [N:0] shl_in(input logic [N:0] v, input logic b);
        return (v << 1) | {{N{1'b0}}, b};
    endfunction

    always_comb begin
        accept_first = bus.enable & bus.start;
        accept_next  = bus.enable & ~bus.start & (state_q == CONV);
        accept       = accept_first | accept_next;
        // A new word restarts from Q = 0, QM = -1 before the first step.
        base_q       = accept_first ? '0 : q_q;
        base_qm      = accept_first ? '1 : qm_q;
        q_d          = q_q;
        qm_d         = qm_q;
        cnt_d        = cnt_q;
        if (accept) begin
            unique case (bus.digit)
                2'b10: begin
                    q_d  = shl_in(base_q, 1'b1);
                    qm_d = shl_in(base_q, 1'b0);
                end
                2'b01: begin
                    q_d  = shl_in(base_qm, 1'b1);
                    qm_d = shl_in(base_qm, 1'b0);
                end
                default: begin
                    q_d  = shl_in(base_q, 1'b0);
                    qm_d = shl_in(base_qm, 1'b1);
                end
            endcase
            cnt_d = accept_first ? CW'(1) : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            qm_q    <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            q_q   <= q_d;
            qm_q  <= qm_d;
            cnt_q <= cnt_d;
            if (accept) begin
                if (cnt_d == CW'(N)) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= CONV;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                end
            end else begin
                done_q <= 1'b0;
                if (state_q == DONE) begin
                    state_q <= IDLE;
                end
            end
        end
    end

    assign bus.result = q_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
`ifdef SD_OTF_QM_OUT_EN
    assign bus.result_m = qm_q;
`endif
endmodule

// File: tb/tb_sd_otf_converter.sv
// Self-checking bench for sd_otf_converter (N=4): directed cases plus random words vs an arithmetic model.
module tb_sd_otf_converter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    sd_otf_converter_if #(.N(N)) bus ();
    sd_otf_converter #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] enc(input int d, input bit alt);
        if (d > 0) return 2'b10;
        if (d < 0) return 2'b01;
        return alt ? 2'b11 : 2'b00;
    endfunction

    // Value of an MSD-first word: sum of d_i * 2^(N-i).
    function automatic int ref_value(input int ds[$]);
        int v = 0;
        for (int i = 0; i < N; i++) v = v + ds[i] * (1 << (N - 1 - i));
        return v;
    endfunction

    task automatic cyc(input bit en, input bit st, input int d, input bit alt);
        @(negedge clk);
        bus.enable = en;
        bus.start  = st;
        bus.digit  = enc(d, alt);
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input int val);
        int vm;
        logic [31:0] e;
        logic [31:0] em;
        e  = 32'(val) & 32'h1F;
        vm = val - 1;
        em = 32'(vm) & 32'h1F;
        check({tag, "_result"}, 32'(bus.result), e);
`ifdef SD_OTF_QM_OUT_EN
        check({tag, "_result_m"}, 32'(bus.result_m), em);
`else
        if (em == 32'hFFFF_FFFF) $display("unreachable");
`endif
    endtask

    task automatic run_word(input int ds[$], input bit alt, input string tag);
        for (int i = 0; i < N; i++) begin
            cyc(1'b1, i == 0, ds[i], alt);
            if (i < N - 1) begin
                check({tag, "_busy"}, 32'(bus.busy), 32'd1);
                check({tag, "_nodone"}, 32'(bus.done), 32'd0);
            end else begin
                check({tag, "_done"}, 32'(bus.done), 32'd1);
                check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
                check_outputs(tag, ref_value(ds));
            end
        end
    endtask

    initial begin
        int ds[$];
        int val;
        logic [N:0] r00;
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.start  = 1'b0;
        bus.digit  = 2'b00;
        #12;
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
`ifdef SD_OTF_QM_OUT_EN
        check("rst_result_m", 32'(bus.result_m), 32'h1F);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Enable without start in IDLE is ignored.
        cyc(1'b1, 1'b0, 1, 1'b0);
        check("idle_discard_busy", 32'(bus.busy), 32'd0);
        check("idle_discard_result", 32'(bus.result), 32'd0);

        ds = '{1, -1, 0, 1};
        run_word(ds, 1'b0, "basic");
        cyc(1'b0, 1'b0, 0, 1'b0);
        check("basic_done_pulse", 32'(bus.done), 32'd0);
        check("basic_hold", 32'(bus.result), 32'd5);
        cyc(1'b0, 1'b1, -1, 1'b0);
        check("basic_hold2", 32'(bus.result), 32'd5);

        ds = '{-1, 0, 0, 0};
        run_word(ds, 1'b0, "neg");
        ds = '{1, 1, 1, 1};
        run_word(ds, 1'b0, "max");
        ds = '{-1, -1, -1, -1};
        run_word(ds, 1'b0, "min");
        ds = '{1, 0, -1, 0};
        run_word(ds, 1'b0, "zero00");
        r00 = bus.result;
        run_word(ds, 1'b1, "zero11");
        check("zero_enc_equal", 32'(bus.result), 32'(r00));

        // Stalled word abandoned by restart.
        cyc(1'b1, 1'b1, 1, 1'b0);
        for (int g = 0; g < 3; g++) begin
            cyc(1'b0, g[0], -1, 1'b0);
            check("stall_busy", 32'(bus.busy), 32'd1);
            check("stall_nodone", 32'(bus.done), 32'd0);
        end
        cyc(1'b1, 1'b0, 0, 1'b0);
        check("stall_nodone2", 32'(bus.done), 32'd0);
        ds = '{-1, 0, 0, 1};
        run_word(ds, 1'b0, "restart");

        // Back-to-back words: second start lands in the done cycle.
        ds = '{0, 1, 1, -1};
        run_word(ds, 1'b0, "b2b_a");
        ds = '{-1, 1, 0, 0};
        run_word(ds, 1'b1, "b2b_b");

        // Reset mid-word.
        cyc(1'b1, 1'b1, 1, 1'b0);
        cyc(1'b1, 1'b0, 1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_result", 32'(bus.result), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
`ifdef SD_OTF_QM_OUT_EN
        check("midrst_result_m", 32'(bus.result_m), 32'h1F);
`endif
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, 1, 1'b0);
            check("postrst_nodone", 32'(bus.done), 32'd0);
            check("postrst_busy", 32'(bus.busy), 32'd0);
        end

        // Random words with random stalls; disabled cycles carry random start/digit.
        for (int w = 0; w < 40; w++) begin
            ds = {};
            for (int i = 0; i < N; i++) ds.push_back(int'($urandom_range(0, 2)) - 1);
            for (int i = 0; i < N; i++) begin
                if (i > 0) begin
                    int gaps;
                    gaps = int'($urandom_range(0, 2));
                    for (int g = 0; g < gaps; g++) begin
                        cyc(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)) - 1, 1'b0);
                        check("rnd_gap_busy", 32'(bus.busy), 32'd1);
                    end
                end
                cyc(1'b1, i == 0, ds[i], 1'($urandom_range(0, 1)));
                if (i == N - 1) begin
                    check("rnd_done", 32'(bus.done), 32'd1);
                    val = ref_value(ds);
                    check_outputs("rnd", val);
                end else begin
                    check("rnd_nodone", 32'(bus.done), 32'd0);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
